// File: rtl/apb_master_bridge_if.sv
// Command, response and APB signal bundle for apb_master_bridge.
// The master modport is the bridge's view; slave is the view of whatever drives commands and models the APB target.
interface apb_master_bridge_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int PADDR_WIDTH = $clog2(DEPTH);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [PADDR_WIDTH-1:0] cmd_addr;
  logic [WIDTH-1:0]       cmd_wdata;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_rdata;
  logic                   rsp_err;

  logic                   PSELx;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [PADDR_WIDTH-1:0] PADDR;
  logic [WIDTH-1:0]       PWDATA;
  logic                   PREADY;
  logic [WIDTH-1:0]       PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: one command at a time through IDLE/SETUP/ACCESS, with a
// registered response and an optional ACCESS-phase timeout.
module apb_master_bridge #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input logic                 PCLK,
  input logic                 PRESETn,
  apb_master_bridge_if.master bus
);
  localparam int PADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                 state_q, state_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [WIDTH-1:0]       pwdata_q, pwdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic cmd_ready;
  logic cmd_hs;
  logic timeout_hit;

  // Wait counter saturates so a stalled slave with the timeout disabled never wraps it.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign cmd_ready   = (state_q == IDLE) && !rsp_valid_q && PRESETn;
  assign cmd_hs      = bus.cmd_valid && cmd_ready;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
          if (timeout_hit) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.PSELx     = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: transaction-level reference model with a per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
module tb_apb_master_bridge;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TO    = 16;
  localparam int TO4   = 4;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b1;
  always #5 PCLK = ~PCLK;

  apb_master_bridge_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  apb_master_bridge_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus4 ();

  apb_master_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TO)) u_dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus)
  );
  apb_master_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TO4)) u_dut4 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus4)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // APB target for the main DUT: memory with a per-transfer wait count.
  logic [WIDTH-1:0] slv_mem [DEPTH];
  int               slv_wait = 0;
  int               cur_wait = 0;
  int               acc_cnt  = 0;
  logic             junk_rdy = 1'b0;
  logic [WIDTH-1:0] junk_data = '0;
  logic             in_acc;
  bit               rr_hold = 1'b0;

  assign in_acc     = bus.PSELx && bus.PENABLE;
  assign bus.PREADY = in_acc ? (acc_cnt >= cur_wait) : junk_rdy;
  assign bus.PRDATA = (in_acc && !bus.PWRITE) ? slv_mem[bus.PADDR] : junk_data;

  always @(posedge PCLK) begin
    if (bus.cmd_valid && bus.cmd_ready) cur_wait <= slv_wait;
    if (in_acc && bus.PREADY) begin
      acc_cnt <= 0;
      if (bus.PWRITE) slv_mem[bus.PADDR] <= bus.PWDATA;
    end else if (in_acc) begin
      acc_cnt <= acc_cnt + 1;
    end else begin
      acc_cnt <= 0;
    end
  end

  always @(posedge PCLK) begin
    #2;
    junk_rdy      = 1'($urandom_range(0, 1));
    junk_data     = WIDTH'($urandom);
    bus.rsp_ready = rr_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Second target, for the short-timeout instance.
  logic t4_rdy = 1'b0;
  assign bus4.PREADY    = t4_rdy;
  assign bus4.PRDATA    = 8'h77;
  assign bus4.rsp_ready = 1'b1;

  // Reference model: a transfer accepted at edge N with w wait states ends at
  // edge N+2+w, or at N+1+TO when w >= TO (timeout).
  int               cyc = 0;
  bit               m_busy = 1'b0, m_rvalid = 1'b0, m_err = 1'b0, m_write = 1'b0;
  int               m_start = 0, m_end = 0;
  logic [AW-1:0]    m_addr = '0;
  logic [WIDTH-1:0] m_wdata = '0, m_rdata = '0;
  logic [WIDTH-1:0] ref_mem [DEPTH];

  initial begin : model
    bit hs_cmd, hs_rsp, timed;
    forever begin
      @(posedge PCLK or negedge PRESETn);
      if (!PRESETn) begin
        m_busy   = 1'b0;
        m_rvalid = 1'b0;
      end else begin
        cyc++;
        hs_cmd = bus.cmd_valid && !m_busy && !m_rvalid;
        hs_rsp = bus.rsp_ready && m_rvalid;
        if (hs_rsp) m_rvalid = 1'b0;
        if (m_busy && cyc == m_end) begin
          m_busy   = 1'b0;
          m_rvalid = 1'b1;
          if (!m_err && m_write) ref_mem[m_addr] = m_wdata;
        end
        if (hs_cmd) begin
          timed   = (slv_wait >= TO);
          m_busy  = 1'b1;
          m_start = cyc;
          m_end   = timed ? cyc + 1 + TO : cyc + 2 + slv_wait;
          m_err   = timed;
          m_write = bus.cmd_write;
          m_addr  = bus.cmd_addr;
          m_wdata = bus.cmd_wdata;
          m_rdata = (bus.cmd_write || timed) ? '0 : ref_mem[bus.cmd_addr];
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_psel", bus.PSELx, 0);
        chk("rst_penable", bus.PENABLE, 0);
        chk("rst_pwrite", bus.PWRITE, 0);
        chk("rst_paddr", bus.PADDR, 0);
        chk("rst_pwdata", bus.PWDATA, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
      end else begin
        chk("cmd_ready", bus.cmd_ready, !m_busy && !m_rvalid);
        chk("psel", bus.PSELx, m_busy);
        chk("penable", bus.PENABLE, m_busy && (cyc >= m_start + 1));
        chk("rsp_valid", bus.rsp_valid, m_rvalid);
        if (m_busy) begin
          chk("paddr", bus.PADDR, m_addr);
          chk("pwrite", bus.PWRITE, m_write);
          chk("pwdata", bus.PWDATA, m_wdata);
        end
        if (m_rvalid) begin
          chk("rsp_rdata", bus.rsp_rdata, m_rdata);
          chk("rsp_err", bus.rsp_err, m_err);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input bit wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input int w);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    slv_wait      = w;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    if (!bus.cmd_ready) chk("cmd_accept_bound", 0, 1);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [WIDTH-1:0] rd, output logic er, output int pen, output int lat);
    int k = 0;
    pen = 0;
    while (!bus.rsp_valid && k < 100) begin
      if (bus.PENABLE) pen++;
      @(negedge PCLK);
      k++;
    end
    lat = k;
    chk("rsp_arrives", bus.rsp_valid, 1);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.cmd_ready && n < 300) begin
      @(negedge PCLK);
      n++;
    end
    chk("idle_bound", bus.cmd_ready, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [WIDTH-1:0] rd;
    logic             er;
    int               pen, lat, k, w, r;

    for (int i = 0; i < DEPTH; i++) begin
      slv_mem[i] = WIDTH'(8'h80 + i);
      ref_mem[i] = WIDTH'(8'h80 + i);
    end
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    bus4.cmd_valid = 1'b0;
    bus4.cmd_write = 1'b0;
    bus4.cmd_addr  = '0;
    bus4.cmd_wdata = '0;

    #1 PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    #2 PRESETn = 1'b1;
    @(negedge PCLK);

    // Zero-wait write
    send(1'b1, 3'd3, 8'hA5, 0);
    chk("w0_psel", bus.PSELx, 1);
    chk("w0_penable_setup", bus.PENABLE, 0);
    chk("w0_paddr", bus.PADDR, 3);
    chk("w0_pwdata", bus.PWDATA, 8'hA5);
    chk("w0_pwrite", bus.PWRITE, 1);
    get_rsp(rd, er, pen, lat);
    chk("w0_latency", lat, 2);
    chk("w0_access_cycles", pen, 1);
    chk("w0_rdata", rd, 0);
    chk("w0_err", er, 0);

    // Read-after-write with one wait state
    send(1'b1, 3'd7, 8'h5C, 1);
    get_rsp(rd, er, pen, lat);
    chk("raw_w_access_cycles", pen, 2);
    chk("raw_w_err", er, 0);
    send(1'b0, 3'd7, 8'h00, 1);
    get_rsp(rd, er, pen, lat);
    chk("raw_r_latency", lat, 3);
    chk("raw_r_access_cycles", pen, 2);
    chk("raw_r_rdata", rd, 8'h5C);
    chk("raw_r_err", er, 0);

    // Five wait states, well under the timeout
    send(1'b1, 3'd1, 8'h3C, 5);
    get_rsp(rd, er, pen, lat);
    chk("ws5_access_cycles", pen, 6);
    chk("ws5_err", er, 0);

    // Short-timeout instance: PREADY stuck low, then a normal read
    wait_idle();
    bus4.cmd_valid = 1'b1;
    bus4.cmd_write = 1'b0;
    bus4.cmd_addr  = 3'd5;
    t4_rdy         = 1'b0;
    chk("to_cmd_ready", bus4.cmd_ready, 1);
    @(negedge PCLK);
    bus4.cmd_valid = 1'b0;
    pen = 0;
    k   = 0;
    while (!bus4.rsp_valid && k < 30) begin
      if (bus4.PENABLE) pen++;
      @(negedge PCLK);
      k++;
    end
    chk("to_rsp_valid", bus4.rsp_valid, 1);
    chk("to_access_cycles", pen, TO4);
    chk("to_err", bus4.rsp_err, 1);
    chk("to_rdata", bus4.rsp_rdata, 0);
    chk("to_psel_dropped", bus4.PSELx, 0);
    @(negedge PCLK);
    t4_rdy         = 1'b1;
    bus4.cmd_valid = 1'b1;
    bus4.cmd_addr  = 3'd2;
    k = 0;
    while (!bus4.cmd_ready && k < 20) begin
      @(negedge PCLK);
      k++;
    end
    @(negedge PCLK);
    bus4.cmd_valid = 1'b0;
    k = 0;
    while (!bus4.rsp_valid && k < 20) begin
      @(negedge PCLK);
      k++;
    end
    chk("to_next_rsp_valid", bus4.rsp_valid, 1);
    chk("to_next_err", bus4.rsp_err, 0);
    chk("to_next_rdata", bus4.rsp_rdata, 8'h77);

    // Response backpressure with a queued command
    send(1'b1, 3'd2, 8'h3E, 0);
    wait_idle();
    rr_hold = 1'b1;
    send(1'b0, 3'd2, 8'h00, 0);
    get_rsp(rd, er, pen, lat);
    chk("bp_rdata_first", rd, 8'h3E);
    fork
      send(1'b0, 3'd5, 8'h00, 0);
      begin
        repeat (3) begin
          @(negedge PCLK);
          chk("bp_hold_valid", bus.rsp_valid, 1);
          chk("bp_hold_rdata", bus.rsp_rdata, 8'h3E);
          chk("bp_hold_cmd_ready", bus.cmd_ready, 0);
        end
        rr_hold = 1'b0;
      end
    join
    get_rsp(rd, er, pen, lat);
    chk("bp_queued_rdata", rd, 8'h85);

    // Reset in the middle of ACCESS
    wait_idle();
    send(1'b0, 3'd4, 8'h00, 30);
    k = 0;
    while (!bus.PENABLE && k < 10) begin
      @(negedge PCLK);
      k++;
    end
    chk("rst_mid_in_access", bus.PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_mid_psel", bus.PSELx, 0);
    chk("rst_mid_penable", bus.PENABLE, 0);
    chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mid_cmd_ready", bus.cmd_ready, 0);
    repeat (3) @(negedge PCLK);
    #2 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("rst_no_stale_rsp", bus.rsp_valid, 0);
    send(1'b0, 3'd0, 8'h00, 1);
    get_rsp(rd, er, pen, lat);
    chk("rst_after_rdata", rd, 8'h80);
    chk("rst_after_err", er, 0);

    // Random traffic
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       w = 0;
      else if (r < 8)  w = $urandom_range(1, 4);
      else if (r == 8) w = $urandom_range(5, 12);
      else             w = $urandom_range(14, 20);
      if ($urandom_range(0, 2) == 0) @(negedge PCLK);
      send(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom), w);
    end

    wait_idle();
    repeat (3) @(negedge PCLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester for the team's APB memory slaves. Takes one-at-a-time commands on a valid/ready interface and drives PSELx/PENABLE/PADDR/PWRITE/PWDATA through the APB IDLE, SETUP and ACCESS phases.
- Samples PREADY/PRDATA and returns a response on a valid/ready interface.
- Used as the bus driver in block-level benches and as the CPU-side bridge in subsystem tops.

Parameters:
- WIDTH, 8: data width of cmd_wdata, PWDATA, PRDATA and rsp_rdata.
- DEPTH, 8: slave word count. Localparam PADDR_WIDTH = $clog2(DEPTH).
- TIMEOUT, 16: maximum ACCESS cycles without PREADY before the transfer is aborted. 0 disables the timeout.

Ports:
- PCLK  in  1  clock, rising edge. The block has one clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid at a PCLK edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  PADDR_WIDTH  target word address.
- cmd_wdata  in  WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  WIDTH  read data; 0 for writes and for errors.
- rsp_err  out  1  1 = transfer ended by timeout.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  PADDR_WIDTH  APB address.
- PWDATA  out  WIDTH  APB write data.
- PREADY  in  1  slave ready.
- PRDATA  in  WIDTH  slave read data.

Behaviour:
- Reset (PRESETn low, asynchronous):
  - State goes to IDLE.
  - PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the timeout counter all go to 0.
  - cmd_ready goes to 0 while reset is asserted.
- All APB outputs and all rsp_* outputs are registered.
- cmd_ready is combinational: cmd_ready = (state == IDLE) && !rsp_valid && PRESETn. Only one transfer is outstanding at a time.
- State IDLE:
  - PSELx = 0, PENABLE = 0.
  - On a cmd handshake, latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- State SETUP (always exactly 1 cycle):
  - PSELx = 1, PENABLE = 0.
  - Clear the timeout counter and go to ACCESS.
- State ACCESS:
  - PSELx = 1, PENABLE = 1. PADDR, PWRITE and PWDATA are held stable for the whole phase.
  - At each edge, sample PREADY.
  - PREADY = 1:
    - Read: rsp_rdata <= PRDATA.
    - Write: rsp_rdata <= 0.
    - rsp_err <= 0, rsp_valid <= 1, PSELx/PENABLE <= 0, go to IDLE.
  - PREADY = 0:
    - Increment the counter.
    - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 on this edge, abort: rsp_err <= 1, rsp_rdata <= 0, rsp_valid <= 1, PSELx/PENABLE <= 0, go to IDLE.
  - The counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.
- Latency, zero-wait slave (PREADY high in the first ACCESS cycle):
  - Cmd handshake at edge N.
  - SETUP during N..N+1, ACCESS during N+1..N+2.
  - rsp_valid high after edge N+2.
  - Every wait state adds one cycle.
- A slave that registers PREADY one cycle after PENABLE gives one wait state, so rsp_valid is high after edge N+3.
- Response:
  - rsp_valid, rsp_rdata and rsp_err hold until the rsp handshake; rsp_valid clears on that edge.
  - The next cmd can be accepted at the edge after rsp_valid clears.
  - With rsp_ready tied high, back-to-back transfers are 4 cycles apart for a zero-wait slave.
- PREADY and PRDATA are ignored outside ACCESS.
- Reset mid-transfer: the APB outputs drop immediately, the transfer is lost and no response is produced.
- With TIMEOUT = 0, ACCESS waits indefinitely.

Test Plan:
- Write, zero-wait slave: cmd write addr 3, data 0xA5 -> SETUP then ACCESS with PADDR=3, PWDATA=0xA5, PWRITE=1; rsp_valid after 2 edges with rsp_err=0, rsp_rdata=0.
- Read-after-write, 1-wait slave: write 0x5C to addr 7, then read addr 7 -> PENABLE high 2 cycles; rsp_rdata=0x5C, rsp_err=0; PADDR stable throughout ACCESS.
- Wait states: slave holds PREADY low 5 cycles, TIMEOUT=16 -> ACCESS lasts 6 cycles; PWDATA/PADDR/PWRITE constant throughout; single response with rsp_err=0.
- Timeout: PREADY stuck low, TIMEOUT=4 -> PSELx/PENABLE drop after 4 ACCESS cycles; rsp_err=1, rsp_rdata=0; next command completes normally.
- Backpressure: rsp_ready low 3 cycles after a read of 0x3E -> rsp_valid and rsp_rdata=0x3E held; cmd_ready=0 until the handshake; a queued cmd is accepted the following edge.
- Reset mid-ACCESS: assert PRESETn low while PENABLE=1 -> PSELx, PENABLE and rsp_valid are 0 immediately; after release, a read of addr 0 returns the slave value with no stale response.
